// File: rtl/pipe_ctl_pkg.sv
// Shared encodings for the Beta pipeline sequencer: PC-select codes, IR-source
// codes, FSM states and the control-output bundle.
package pipe_ctl_pkg;

  localparam logic [2:0] PC_SEL_INC   = 3'd0;
  localparam logic [2:0] PC_SEL_BR    = 3'd1;
  localparam logic [2:0] PC_SEL_JMP   = 3'd2;
  localparam logic [2:0] PC_SEL_ILLOP = 3'd3;
  localparam logic [2:0] PC_SEL_XADDR = 3'd4;
  localparam logic [2:0] PC_SEL_RESET = 3'd5;

  localparam logic [1:0] IR_SRC_DATA   = 2'd0;
  localparam logic [1:0] IR_SRC_NOP    = 2'd1;
  localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;
  localparam logic [1:0] IR_SRC_HOLD   = 2'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_XCPT = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0] pc_sel;
    logic       pc_we;
    logic [1:0] ir_src_if;
    logic [1:0] ir_src_dec;
    logic       irq_ack;
    logic       busy;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{
    pc_sel:     PC_SEL_RESET,
    pc_we:      1'b1,
    ir_src_if:  IR_SRC_NOP,
    ir_src_dec: IR_SRC_NOP,
    irq_ack:    1'b0,
    busy:       1'b0
  };

  function automatic logic br_taken(input logic op_jmp, input logic op_beq,
                                    input logic op_bne, input logic zr);
    return op_jmp | (op_beq & zr) | (op_bne & ~zr);
  endfunction

  // Counter width able to hold the value n (never narrower than 1 bit).
  function automatic int unsigned holdoff_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_ctl_holdoff.sv
// Interrupt hold-off timer: loadable down-counter saturating at zero, with a
// zero flag that gates interrupt acceptance.
module pipe_ctl_holdoff
  import pipe_ctl_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int unsigned W = holdoff_width(LOAD_VAL);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LOAD_VAL);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctl.sv
// Beta 5-stage pipeline sequencer: PC select / IR-source control, exception
// entry FSM and interrupt hold-off. PIPE_CTL_PERF_EN adds stall/flush counters.
module pipe_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int unsigned IRQ_HOLDOFF = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             op_jmp,
  input  logic             op_beq,
  input  logic             op_bne,
  input  logic             zr,
  input  logic             illop,
  input  logic             irq,
  input  logic             kernel,
  input  logic             imem_valid,
  output logic [2:0]       pc_sel,
  output logic             pc_we,
  output logic [1:0]       ir_src_if,
  output logic [1:0]       ir_src_dec,
  output logic             irq_ack,
  output logic             busy
`ifdef PIPE_CTL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (IRQ_HOLDOFF < 1 || CNT_W < 1) begin : g_bad_params
    $error("pipe_ctl: IRQ_HOLDOFF and CNT_W must both be at least 1");
  end

  state_e state, state_nxt;
  ctl_t   run_ctl, ctl;
  logic   boot;
  logic   br, irq_ok, hold_zero, hold_load;
  logic   take_br, take_xcpt, stall_run;

  // Holds the reset-vector select until the first edge after rst releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot <= 1'b1;
    end else begin
      boot <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  pipe_ctl_holdoff #(
    .LOAD_VAL (IRQ_HOLDOFF)
  ) u_holdoff (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .zero (hold_zero)
  );

  assign br     = br_taken(op_jmp, op_beq, op_bne, zr);
  assign irq_ok = irq & ~kernel & hold_zero;

  // Next state and control outputs; rst itself is folded in below so that it
  // never reaches a flop's data input.
  always_comb begin
    run_ctl = '{
      pc_sel:     PC_SEL_INC,
      pc_we:      1'b0,
      ir_src_if:  IR_SRC_NOP,
      ir_src_dec: IR_SRC_NOP,
      irq_ack:    1'b0,
      busy:       1'b0
    };
    state_nxt = ST_RUN;
    hold_load = 1'b0;
    take_br   = 1'b0;
    take_xcpt = 1'b0;
    stall_run = 1'b0;

    if (boot) begin
      run_ctl = CTL_RESET;
    end else begin
      case (state)
        ST_RUN: begin
          if (illop) begin
            run_ctl.pc_sel     = PC_SEL_ILLOP;
            run_ctl.pc_we      = 1'b1;
            run_ctl.ir_src_dec = IR_SRC_EXCEPT;
            take_xcpt          = 1'b1;
            state_nxt          = ST_XCPT;
          end else if (irq_ok && !stall) begin
            run_ctl.pc_sel     = PC_SEL_XADDR;
            run_ctl.pc_we      = 1'b1;
            run_ctl.ir_src_dec = IR_SRC_EXCEPT;
            run_ctl.irq_ack    = 1'b1;
            take_xcpt          = 1'b1;
            state_nxt          = ST_XCPT;
          end else if (stall) begin
            // Decode re-latches its word; exec gets a bubble.
            run_ctl.ir_src_if  = IR_SRC_HOLD;
            run_ctl.ir_src_dec = IR_SRC_NOP;
            stall_run          = 1'b1;
          end else if (br) begin
            run_ctl.pc_sel     = op_jmp ? PC_SEL_JMP : PC_SEL_BR;
            run_ctl.pc_we      = 1'b1;
            run_ctl.ir_src_dec = IR_SRC_DATA;
            take_br            = 1'b1;
          end else if (!imem_valid) begin
            run_ctl.ir_src_dec = IR_SRC_DATA;
          end else begin
            run_ctl.pc_we      = 1'b1;
            run_ctl.ir_src_if  = IR_SRC_DATA;
            run_ctl.ir_src_dec = IR_SRC_DATA;
          end
        end
        ST_XCPT: begin
          run_ctl.pc_we     = imem_valid;
          run_ctl.ir_src_if = imem_valid ? IR_SRC_DATA : IR_SRC_NOP;
          run_ctl.busy      = 1'b1;
          hold_load         = 1'b1;
          state_nxt         = ST_RUN;
        end
      endcase
    end
  end

  assign ctl        = rst ? CTL_RESET : run_ctl;
  assign pc_sel     = ctl.pc_sel;
  assign pc_we      = ctl.pc_we;
  assign ir_src_if  = ctl.ir_src_if;
  assign ir_src_dec = ctl.ir_src_dec;
  assign irq_ack    = ctl.irq_ack;
  assign busy       = ctl.busy;

`ifdef PIPE_CTL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_run) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (take_br || take_xcpt) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_perf;
  assign unused_perf = ^{take_br, take_xcpt, stall_run};
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Self-checking bench for pipe_ctl: directed vector table, reset/stall
// sequences and randomized stimulus against a rule-level reference model.
module tb_pipe_ctl;
  import pipe_ctl_pkg::*;

  localparam int unsigned HOLDOFF = 4;

  typedef struct packed {
    logic stall, jmp, beq, bne, zr, illop, irq, kernel, iv;
  } in_t;

  typedef struct packed {
    logic [2:0] sel;
    logic       we;
    logic [1:0] ir_if, ir_dec;
    logic       ack, busy;
  } out_t;

  typedef struct packed {
    in_t  vin;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic stall, op_jmp, op_beq, op_bne, zr, illop, irq, kernel, imem_valid;
  logic [2:0] pc_sel;
  logic pc_we, irq_ack, busy;
  logic [1:0] ir_src_if, ir_src_dec;
`ifdef PIPE_CTL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit          m_boot, m_xcpt;
  int          m_hold;
  logic [15:0] m_sc, m_fc;

  always #5 clk = ~clk;

  pipe_ctl #(.IRQ_HOLDOFF(HOLDOFF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op_jmp(op_jmp), .op_beq(op_beq),
    .op_bne(op_bne), .zr(zr), .illop(illop), .irq(irq), .kernel(kernel),
    .imem_valid(imem_valid), .pc_sel(pc_sel), .pc_we(pc_we),
    .ir_src_if(ir_src_if), .ir_src_dec(ir_src_dec), .irq_ack(irq_ack),
    .busy(busy)
`ifdef PIPE_CTL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic out_t mk(input logic [2:0] s, input logic w,
                              input logic [1:0] fi, input logic [1:0] fd,
                              input logic a, input logic b);
    out_t o;
    o.sel = s; o.we = w; o.ir_if = fi; o.ir_dec = fd; o.ack = a; o.busy = b;
    return o;
  endfunction

  // Expected outputs for the current cycle, from the sequencing rules.
  function automatic out_t model_out(input in_t v, input logic r);
    bit irq_ok, taken;
    if (r || m_boot) return mk(PC_SEL_RESET, 1, IR_SRC_NOP, IR_SRC_NOP, 0, 0);
    if (m_xcpt) return mk(PC_SEL_INC, v.iv, v.iv ? IR_SRC_DATA : IR_SRC_NOP, IR_SRC_NOP, 0, 1);
    irq_ok = v.irq && !v.kernel && (m_hold == 0);
    taken  = v.jmp || (v.beq && v.zr) || (v.bne && !v.zr);
    if (v.illop)            return mk(PC_SEL_ILLOP, 1, IR_SRC_NOP, IR_SRC_EXCEPT, 0, 0);
    if (irq_ok && !v.stall) return mk(PC_SEL_XADDR, 1, IR_SRC_NOP, IR_SRC_EXCEPT, 1, 0);
    if (v.stall)            return mk(PC_SEL_INC, 0, IR_SRC_HOLD, IR_SRC_NOP, 0, 0);
    if (taken)              return mk(v.jmp ? PC_SEL_JMP : PC_SEL_BR, 1, IR_SRC_NOP, IR_SRC_DATA, 0, 0);
    if (!v.iv)              return mk(PC_SEL_INC, 0, IR_SRC_NOP, IR_SRC_DATA, 0, 0);
    return mk(PC_SEL_INC, 1, IR_SRC_DATA, IR_SRC_DATA, 0, 0);
  endfunction

  task automatic model_step(input in_t v, input logic r);
    bit irq_ok, taken, exc;
    if (r) begin
      m_boot = 1; m_xcpt = 0; m_hold = 0; m_sc = 0; m_fc = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_xcpt) begin
      m_xcpt = 0; m_hold = HOLDOFF;
    end else begin
      irq_ok = v.irq && !v.kernel && (m_hold == 0);
      taken  = v.jmp || (v.beq && v.zr) || (v.bne && !v.zr);
      exc    = v.illop || (irq_ok && !v.stall);
      if (!exc && v.stall) m_sc = m_sc + 16'd1;
      if (exc || (!v.stall && taken)) m_fc = m_fc + 16'd1;
      m_hold = (m_hold > 0) ? m_hold - 1 : 0;
      m_xcpt = exc;
    end
  endtask

  task automatic drive(input in_t v);
    stall = v.stall; op_jmp = v.jmp; op_beq = v.beq; op_bne = v.bne; zr = v.zr;
    illop = v.illop; irq = v.irq; kernel = v.kernel; imem_valid = v.iv;
  endtask

  // pc_sel is only meaningful when the PC is written.
  task automatic check(input string name, input out_t e);
    bit ok;
    n_checks++;
    ok = (pc_we === e.we) && (ir_src_if === e.ir_if) && (ir_src_dec === e.ir_dec) &&
         (irq_ack === e.ack) && (busy === e.busy) && (!e.we || pc_sel === e.sel);
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got sel=%0d we=%0d if=%0d dec=%0d ack=%0d busy=%0d, expected sel=%0d we=%0d if=%0d dec=%0d ack=%0d busy=%0d",
               name, pc_sel, pc_we, ir_src_if, ir_src_dec, irq_ack, busy,
               e.sel, e.we, e.ir_if, e.ir_dec, e.ack, e.busy);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One cycle: called at posedge+1, checks near the falling edge, then steps.
  task automatic run_vec(input string name, input in_t v, input logic r,
                         input bit use_exp, input out_t e);
    rst = r;
    drive(v);
    #4;
    check(name, use_exp ? e : model_out(v, r));
    @(posedge clk);
    model_step(v, r);
    #1;
  endtask

  vec_t tbl[26];
  in_t  idle, rv;

  initial begin
    // Inputs:      s j q n z i r k v
    tbl[0]  = '{9'b000000001, mk(PC_SEL_INC,   1, IR_SRC_DATA, IR_SRC_DATA,   0, 0)};
    tbl[1]  = '{9'b000000000, mk(PC_SEL_INC,   0, IR_SRC_NOP,  IR_SRC_DATA,   0, 0)};
    tbl[2]  = '{9'b001010001, mk(PC_SEL_BR,    1, IR_SRC_NOP,  IR_SRC_DATA,   0, 0)};
    tbl[3]  = '{9'b001000001, mk(PC_SEL_INC,   1, IR_SRC_DATA, IR_SRC_DATA,   0, 0)};
    tbl[4]  = '{9'b000110001, mk(PC_SEL_INC,   1, IR_SRC_DATA, IR_SRC_DATA,   0, 0)};
    tbl[5]  = '{9'b000100001, mk(PC_SEL_BR,    1, IR_SRC_NOP,  IR_SRC_DATA,   0, 0)};
    tbl[6]  = '{9'b010000001, mk(PC_SEL_JMP,   1, IR_SRC_NOP,  IR_SRC_DATA,   0, 0)};
    tbl[7]  = '{9'b110000001, mk(PC_SEL_INC,   0, IR_SRC_HOLD, IR_SRC_NOP,    0, 0)};
    tbl[8]  = '{9'b101010001, mk(PC_SEL_INC,   0, IR_SRC_HOLD, IR_SRC_NOP,    0, 0)};
    tbl[9]  = '{9'b000000111, mk(PC_SEL_INC,   1, IR_SRC_DATA, IR_SRC_DATA,   0, 0)};
    tbl[10] = '{9'b100000101, mk(PC_SEL_INC,   0, IR_SRC_HOLD, IR_SRC_NOP,    0, 0)};
    tbl[11] = '{9'b000000101, mk(PC_SEL_XADDR, 1, IR_SRC_NOP,  IR_SRC_EXCEPT, 1, 0)};
    tbl[12] = '{9'b111011101, mk(PC_SEL_INC,   1, IR_SRC_DATA, IR_SRC_NOP,    0, 1)};
    for (int i = 13; i < 17; i++)
      tbl[i] = '{9'b000000101, mk(PC_SEL_INC,  1, IR_SRC_DATA, IR_SRC_DATA,   0, 0)};
    tbl[17] = '{9'b000001101, mk(PC_SEL_ILLOP, 1, IR_SRC_NOP,  IR_SRC_EXCEPT, 0, 0)};
    tbl[18] = '{9'b000000100, mk(PC_SEL_INC,   0, IR_SRC_NOP,  IR_SRC_NOP,    0, 1)};
    for (int i = 19; i < 23; i++)
      tbl[i] = '{9'b000000101, mk(PC_SEL_INC,  1, IR_SRC_DATA, IR_SRC_DATA,   0, 0)};
    tbl[23] = '{9'b000000101, mk(PC_SEL_XADDR, 1, IR_SRC_NOP,  IR_SRC_EXCEPT, 1, 0)};
    tbl[24] = '{9'b000000001, mk(PC_SEL_INC,   1, IR_SRC_DATA, IR_SRC_NOP,    0, 1)};
    tbl[25] = '{9'b000000001, mk(PC_SEL_INC,   1, IR_SRC_DATA, IR_SRC_DATA,   0, 0)};

    idle = 9'b000000001;
    rst = 1'b1;
    drive(idle);
    m_boot = 1; m_xcpt = 0; m_hold = 0; m_sc = 0; m_fc = 0;

    // Power-on reset and release
    #2 check("reset_state", mk(PC_SEL_RESET, 1, IR_SRC_NOP, IR_SRC_NOP, 0, 0));
`ifdef PIPE_CTL_PERF_EN
    check_cnt("reset_stall_cnt", stall_cnt, 16'd0);
    check_cnt("reset_flush_cnt", flush_cnt, 16'd0);
`endif
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("boot_vector", mk(PC_SEL_RESET, 1, IR_SRC_NOP, IR_SRC_NOP, 0, 0));
    @(posedge clk);
    model_step(idle, 1'b0);
    #1;

    // Directed vector table
    for (int i = 0; i < 26; i++)
      run_vec($sformatf("vec%0d", i), tbl[i].vin, 1'b0, 1, tbl[i].exp);
`ifdef PIPE_CTL_PERF_EN
    check_cnt("table_stall_cnt", stall_cnt, 16'd3);
    check_cnt("table_flush_cnt", flush_cnt, 16'd6);
`endif

    // Async reset asserted mid-XCPT
    run_vec("illop_enter", 9'b000001001, 1'b0, 1,
            mk(PC_SEL_ILLOP, 1, IR_SRC_NOP, IR_SRC_EXCEPT, 0, 0));
    #2 rst = 1'b1;
    #1 check("async_rst_in_xcpt", mk(PC_SEL_RESET, 1, IR_SRC_NOP, IR_SRC_NOP, 0, 0));
    @(posedge clk);
    model_step(idle, 1'b1);
    #4 rst = 1'b0;
    #1 check("rst_release_vector", mk(PC_SEL_RESET, 1, IR_SRC_NOP, IR_SRC_NOP, 0, 0));
    @(posedge clk);
    model_step(idle, 1'b0);
    #1;
    run_vec("after_reset_run", idle, 1'b0, 1, mk(PC_SEL_INC, 1, IR_SRC_DATA, IR_SRC_DATA, 0, 0));

    // Two-cycle stall
    for (int i = 0; i < 2; i++)
      run_vec($sformatf("stall2_%0d", i), 9'b100000001, 1'b0, 1,
              mk(PC_SEL_INC, 0, IR_SRC_HOLD, IR_SRC_NOP, 0, 0));
    run_vec("stall_release", idle, 1'b0, 1, mk(PC_SEL_INC, 1, IR_SRC_DATA, IR_SRC_DATA, 0, 0));
`ifdef PIPE_CTL_PERF_EN
    check_cnt("stall2_cnt", stall_cnt, 16'd2);
    check_cnt("stall2_flush", flush_cnt, 16'd0);
`endif

    // Randomized stimulus against the reference model
    for (int c = 0; c < 800; c++) begin
      rv.stall  = ($urandom_range(99) < 20);
      rv.jmp    = ($urandom_range(99) < 10);
      rv.beq    = ($urandom_range(99) < 15);
      rv.bne    = ($urandom_range(99) < 15);
      rv.zr     = ($urandom_range(99) < 50);
      rv.illop  = ($urandom_range(99) < 5);
      rv.irq    = ($urandom_range(99) < 35);
      rv.kernel = ($urandom_range(99) < 25);
      rv.iv     = ($urandom_range(99) < 85);
      run_vec($sformatf("rand%0d", c), rv, ($urandom_range(99) < 2), 0, '0);
`ifdef PIPE_CTL_PERF_EN
      if (c % 100 == 99) begin
        check_cnt("rand_stall_cnt", stall_cnt, m_sc);
        check_cnt("rand_flush_cnt", flush_cnt, m_fc);
      end
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctl.md
Name: pipe_ctl

Overview:
- Central pipeline sequencer for the 5-stage Beta core; sits beside the decode stage.
- Takes hazard, branch and exception inputs from decode, plus the fetch-ready signal and the interrupt line.
- Drives the PC-select mux, the PC write enable and the IR-source muxes of the fetch and decode stages.
- Owns the exception-entry FSM and the interrupt hold-off counter.

Parameters:
- IRQ_HOLDOFF, 4: cycles after an exception entry during which irq is ignored; minimum 1.
- CNT_W, 16: width of the optional performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  load-use hazard from decode.
- op_jmp  in  1  JMP in decode.
- op_beq  in  1  BEQ in decode.
- op_bne  in  1  BNE in decode.
- zr  in  1  decode RA operand is zero.
- illop  in  1  decode holds an unimplemented opcode.
- irq  in  1  level-sensitive external interrupt.
- kernel  in  1  PC[31] of the decode instruction (supervisor mode).
- imem_valid  in  1  fetch word valid.
- pc_sel  out  3  PC mux select.
- pc_we  out  1  fetch PC register write enable.
- ir_src_if  out  2  fetch IR-source select.
- ir_src_dec  out  2  decode IR-source select, feeding exec.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.
- busy  out  1  high while not in RUN.
- stall_cnt  out  CNT_W  stall cycles; only with PIPE_CTL_PERF_EN.
- flush_cnt  out  CNT_W  taken branches plus exceptions; only with PIPE_CTL_PERF_EN.

Behaviour:
- Reset (async, rst=1):
  - FSM=RUN, hold-off counter=0, counters=0.
  - Outputs: pc_sel=PC_SEL_RESET, pc_we=1, ir_src_if=NOP, ir_src_dec=NOP, irq_ack=0, busy=0.
  - After rst deasserts, the first edge loads the reset vector.
- Outputs are combinational from FSM state and inputs. FSM and counters are registered.
- br_taken = op_jmp | (op_beq & zr) | (op_bne & ~zr).
- irq_ok = irq & ~kernel & (holdoff==0).
- RUN priority, highest first:
  - illop: pc_sel=ILLOP, pc_we=1, ir_src_dec=EXCEPT, ir_src_if=NOP; go to XCPT.
  - irq_ok & ~stall: pc_sel=XADDR, pc_we=1, ir_src_dec=EXCEPT, ir_src_if=NOP, irq_ack=1; go to XCPT.
  - stall: pc_we=0, ir_src_if=HOLD (decode re-latches the same word), ir_src_dec=NOP (bubble to exec).
  - br_taken: pc_sel = op_jmp ? JMP : BR, pc_we=1, ir_src_if=NOP (squash the slot), ir_src_dec=DATA.
  - ~imem_valid: pc_we=0, ir_src_if=NOP, ir_src_dec=DATA.
  - otherwise: pc_sel=INC, pc_we=1, ir_src_if=DATA, ir_src_dec=DATA.
- XCPT (exactly 1 cycle):
  - pc_sel=INC, pc_we=imem_valid, ir_src_if = imem_valid ? DATA : NOP, ir_src_dec=NOP.
  - stall, branch, illop and irq are all ignored.
  - busy=1.
  - Hold-off counter loads IRQ_HOLDOFF.
  - Next state: RUN.
- Hold-off counter decrements by 1 each cycle while nonzero and saturates at 0.
- Simultaneous events:
  - illop beats irq; irq stays pending because it is level-sensitive.
  - An interrupt arriving during a stall waits until the stall clears.
  - Stall beats branch: a branch whose operand is stalled resolves only after the stall.
- rst asserted mid-XCPT returns immediately to RUN with the reset outputs.

Optional Feature:
- Macro: PIPE_CTL_PERF_EN.
- Defined:
  - stall_cnt increments each RUN cycle with stall=1.
  - flush_cnt increments on each taken branch and each exception entry.
  - Both wrap at 2^CNT_W and clear on rst.
- Undefined: stall_cnt and flush_cnt ports and their logic are absent.

Decomposition:
- Shared defines/package additions:
  - PC_SEL_INC=0, PC_SEL_BR=1, PC_SEL_JMP=2, PC_SEL_ILLOP=3, PC_SEL_XADDR=4, PC_SEL_RESET=5.
  - IR_SRC_HOLD (new 2-bit code, alongside the existing IR_SRC_DATA, IR_SRC_NOP and IR_SRC_EXCEPT).
  - FSM state enum {RUN, XCPT}.
- Sub-module: pipe_ctl_holdoff, a loadable saturating down-counter with a zero flag.

Test Plan:
- Reset: rst pulsed mid-cycle (async) -> outputs reset immediately; first edge after release gives pc_sel=5, then pc_sel=0, pc_we=1, ir_src_if=DATA.
- Stall: stall=1 for 2 cycles -> pc_we=0, ir_src_if=HOLD, ir_src_dec=NOP for both cycles; with PIPE_CTL_PERF_EN, stall_cnt=2.
- Branches: op_beq=1, zr=1 -> pc_sel=BR, ir_src_if=NOP; op_bne=1, zr=1 -> pc_sel=INC; op_jmp=1 -> pc_sel=JMP.
- Interrupt: irq=1, kernel=0 -> irq_ack=1, pc_sel=XADDR, ir_src_dec=EXCEPT, busy=1 next cycle; irq held -> next irq_ack no earlier than IRQ_HOLDOFF+1 cycles later; kernel=1 -> never acked.
- Illegal opcode with interrupt: illop=1 and irq=1 together -> pc_sel=ILLOP, irq_ack=0; irq is acked later, once hold-off expires.
- Priority and fetch: irq=1 with stall=1 -> no ack until stall drops; imem_valid=0 -> pc_we=0, ir_src_if=NOP.
